// File: rtl/avalon_note_master.sv
// Purpose: Avalon-MM write master turning note-on/off events into synth register writes
//          (FREQ, AMP1, AMP0, KEY per voice), with an 8-voice allocation table.
// Latency: note-on 4 writes in cycles 2-5, ready again in cycle 6; matched note-off 1 write,
//          ready in cycle 3; unmatched note-off ready in cycle 2 (plus any waitrequest cycles).
// Backpressure: EV_READY low while an event is in flight; AVM_WAITREQUEST stalls the FSM with
//               address/data held stable.
// Ports:
//   CLK, RESET (sync, active-low)       clock / reset
//   EV_VALID/EV_READY/EV_ON/EV_NOTE/    event handshake and payload
//   EV_AMP1/EV_AMP0
//   AVM_ADDR/AVM_BYTE_EN/AVM_WRITE/     Avalon-MM write master (no reads)
//   AVM_CS/AVM_WRITEDATA/AVM_WAITREQUEST
//   VOICE_BUSY                          per-voice active flag
//   DROP_COUNT                          unmatched note-offs, saturating
module avalon_note_master #(
  parameter int VOICES    = 8,
  parameter int KEY_BASE  = 32,
  parameter int FREQ_BASE = 40,
  parameter int AMP1_BASE = 48,
  parameter int AMP0_BASE = 56
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EV_VALID,
  output logic              EV_READY,
  input  logic              EV_ON,
  input  logic [6:0]        EV_NOTE,
  input  logic [15:0]       EV_AMP1,
  input  logic [15:0]       EV_AMP0,
  output logic [5:0]        AVM_ADDR,
  output logic [3:0]        AVM_BYTE_EN,
  output logic              AVM_WRITE,
  output logic              AVM_CS,
  output logic [31:0]       AVM_WRITEDATA,
  input  logic              AVM_WAITREQUEST,
  output logic [VOICES-1:0] VOICE_BUSY,
  output logic [15:0]       DROP_COUNT
);

  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WR_FREQ, WR_AMP1, WR_AMP0, WR_KEY
  } state_t;

  state_t            state_q, state_d;
  logic              ev_on_q, ev_on_d;
  logic [6:0]        note_q, note_d;
  logic [15:0]       amp1_q, amp1_d;
  logic [15:0]       amp0_q, amp0_d;
  logic [VW-1:0]     voice_q, voice_d;
  logic [VW-1:0]     steal_q, steal_d;
  logic [VOICES-1:0] act_q, act_d;
  logic [6:0]        vnote_q [VOICES];
  logic [6:0]        vnote_d [VOICES];
  logic [15:0]       drop_q, drop_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic [5:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;

  // Table search: the loop runs high-to-low so the lowest index wins.
  logic          hit, free;
  logic [VW-1:0] hit_idx, free_idx;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (act_q[i] && (vnote_q[i] == note_q)) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!act_q[i]) begin
        free     = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ev_on_d = ev_on_q;
    note_d  = note_q;
    amp1_d  = amp1_q;
    amp0_d  = amp0_q;
    voice_d = voice_q;
    steal_d = steal_q;
    act_d   = act_q;
    vnote_d = vnote_q;
    drop_d  = drop_q;
    ready_d = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (EV_VALID && ready_q) begin
          ev_on_d = EV_ON;
          note_d  = EV_NOTE;
          amp1_d  = EV_AMP1;
          amp0_d  = EV_AMP0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (ev_on_q) begin
          if (hit) begin
            voice_d = hit_idx;
          end else if (free) begin
            voice_d = free_idx;
          end else begin
            voice_d = steal_q;
            steal_d = (steal_q == VW'(VOICES - 1)) ? '0 : steal_q + 1'b1;
          end
          state_d = WR_FREQ;
        end else if (hit) begin
          voice_d = hit_idx;
          state_d = WR_KEY;
        end else begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = IDLE;
        end
      end
      WR_FREQ: if (!AVM_WAITREQUEST) state_d = WR_AMP1;
      WR_AMP1: if (!AVM_WAITREQUEST) state_d = WR_AMP0;
      WR_AMP0: if (!AVM_WAITREQUEST) state_d = WR_KEY;
      WR_KEY: begin
        if (!AVM_WAITREQUEST) begin
          // Gate write done: the voice now reflects this event.
          act_d[voice_q] = ev_on_q;
          if (ev_on_q) vnote_d[voice_q] = note_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with the WR_* cycles.
    ready_d = (state_d == IDLE);
    case (state_d)
      WR_FREQ: begin
        wr_d   = 1'b1;
        addr_d = 6'(FREQ_BASE) + 6'(voice_d);
        data_d = {25'b0, note_d};
      end
      WR_AMP1: begin
        wr_d   = 1'b1;
        addr_d = 6'(AMP1_BASE) + 6'(voice_d);
        data_d = {16'b0, amp1_d};
      end
      WR_AMP0: begin
        wr_d   = 1'b1;
        addr_d = 6'(AMP0_BASE) + 6'(voice_d);
        data_d = {16'b0, amp0_d};
      end
      WR_KEY: begin
        wr_d   = 1'b1;
        addr_d = 6'(KEY_BASE) + 6'(voice_d);
        data_d = {31'b0, ev_on_d};
      end
      default: wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      ev_on_q <= 1'b0;
      note_q  <= '0;
      amp1_q  <= '0;
      amp0_q  <= '0;
      voice_q <= '0;
      steal_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < VOICES; i++) vnote_q[i] <= '0;
      drop_q  <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ev_on_q <= ev_on_d;
      note_q  <= note_d;
      amp1_q  <= amp1_d;
      amp0_q  <= amp0_d;
      voice_q <= voice_d;
      steal_q <= steal_d;
      act_q   <= act_d;
      vnote_q <= vnote_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign EV_READY      = ready_q;
  assign AVM_WRITE     = wr_q;
  assign AVM_CS        = wr_q;
  assign AVM_BYTE_EN   = {4{wr_q}};
  assign AVM_ADDR      = addr_q;
  assign AVM_WRITEDATA = data_q;
  assign VOICE_BUSY    = act_q;
  assign DROP_COUNT    = drop_q;

endmodule

// File: tb/tb_avalon_note_master.sv
// Purpose: randomized + directed bench for avalon_note_master against a voice-table model.
// Latency: checks event-to-ready cycle counts including inserted waitrequest cycles.
// Backpressure: drives AVM_WAITREQUEST randomly or in a fixed burst during AMP1 writes.
module tb_avalon_note_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EV_VALID = 1'b0;
  logic        EV_READY;
  logic        EV_ON = 1'b0;
  logic [6:0]  EV_NOTE = '0;
  logic [15:0] EV_AMP1 = '0;
  logic [15:0] EV_AMP0 = '0;
  logic [5:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic        AVM_WRITE;
  logic        AVM_CS;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic [7:0]  VOICE_BUSY;
  logic [15:0] DROP_COUNT;

  avalon_note_master dut (
    .CLK(CLK), .RESET(RESET),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_ON(EV_ON), .EV_NOTE(EV_NOTE),
    .EV_AMP1(EV_AMP1), .EV_AMP0(EV_AMP0),
    .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITE(AVM_WRITE), .AVM_CS(AVM_CS),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST),
    .VOICE_BUSY(VOICE_BUSY), .DROP_COUNT(DROP_COUNT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: what the synth's voice allocation should look like.
  bit       m_act [8];
  bit [6:0] m_note [8];
  int       m_ptr  = 0;
  int       m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = m_act[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i]  = 1'b0;
      m_note[i] = '0;
    end
    m_ptr  = 0;
    m_drop = 0;
  endtask

  // wmode: 0 no waits, 1 random waits, 2 three-cycle stall on the AMP1 write
  task automatic do_event(input bit on, input bit [6:0] note, input bit [15:0] a1,
                          input bit [15:0] a0, input int wmode);
    logic [37:0] exp_w[$];
    logic [37:0] obs_w[$];
    int v, exp_rdy, n, waits, guard;
    bit done, held;
    logic [5:0]  p_addr;
    logic [31:0] p_data;

    v = -1;
    if (on) begin
      for (int i = 0; i < 8; i++) if (v < 0 && m_act[i] && m_note[i] == note) v = i;
      for (int i = 0; i < 8; i++) if (v < 0 && !m_act[i]) v = i;
      if (v < 0) begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % 8;
      end
      exp_w.push_back({6'(40 + v), 25'b0, note});
      exp_w.push_back({6'(48 + v), 16'b0, a1});
      exp_w.push_back({6'(56 + v), 16'b0, a0});
      exp_w.push_back({6'(32 + v), 32'd1});
      m_act[v]  = 1'b1;
      m_note[v] = note;
      exp_rdy = 6;
    end else begin
      for (int i = 0; i < 8; i++) if (v < 0 && m_act[i] && m_note[i] == note) v = i;
      if (v >= 0) begin
        exp_w.push_back({6'(32 + v), 32'd0});
        m_act[v] = 1'b0;
        exp_rdy = 3;
      end else begin
        if (m_drop < 65535) m_drop++;
        exp_rdy = 2;
      end
    end

    guard = 0;
    while (EV_READY !== 1'b1 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(EV_READY), 32'd1);

    EV_VALID = 1'b1; EV_ON = on; EV_NOTE = note; EV_AMP1 = a1; EV_AMP0 = a0;
    @(posedge CLK);
    n = 0; waits = 0; done = 1'b0; held = 1'b0; p_addr = '0; p_data = '0;
    while (!done) begin
      @(negedge CLK);
      n++;
      EV_VALID = 1'b0;
      if (EV_READY === 1'b1) begin
        done = 1'b1;
      end else if (n > 60) begin
        chk("latency_timeout", 32'(n), 32'(exp_rdy + waits));
        done = 1'b1;
      end else if (AVM_WRITE === 1'b1) begin
        chk("byte_en", 32'(AVM_BYTE_EN), 32'hF);
        chk("cs", 32'(AVM_CS), 32'd1);
        if (held) begin
          chk("hold_addr", 32'(AVM_ADDR), 32'(p_addr));
          chk("hold_data", AVM_WRITEDATA, p_data);
        end
        if (wmode == 1)
          AVM_WAITREQUEST = (waits < 4) && ($urandom_range(0, 2) == 0);
        else if (wmode == 2)
          AVM_WAITREQUEST = (AVM_ADDR >= 6'd48) && (AVM_ADDR < 6'd56) && (waits < 3);
        else
          AVM_WAITREQUEST = 1'b0;
        if (AVM_WAITREQUEST) begin
          waits++;
          held   = 1'b1;
          p_addr = AVM_ADDR;
          p_data = AVM_WRITEDATA;
        end else begin
          held = 1'b0;
          obs_w.push_back({AVM_ADDR, AVM_WRITEDATA});
        end
      end else begin
        AVM_WAITREQUEST = 1'b0;
        held = 1'b0;
        if (AVM_BYTE_EN !== 4'h0 || AVM_CS !== 1'b0)
          chk("idle_bus", {28'(0), AVM_BYTE_EN}, 32'd0);
      end
    end
    AVM_WAITREQUEST = 1'b0;

    chk("ready_cycle", 32'(n), 32'(exp_rdy + waits));
    chk("write_count", 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      chk("wr_addr", 32'(obs_w[i][37:32]), 32'(exp_w[i][37:32]));
      chk("wr_data", obs_w[i][31:0], exp_w[i][31:0]);
    end
    chk("voice_busy", 32'(VOICE_BUSY), 32'(model_busy()));
    chk("drop_count", 32'(DROP_COUNT), 32'(m_drop));
  endtask

  initial begin
    int guard;
    model_reset();

    // Reset state
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(EV_READY), 32'd0);
    chk("rst_write", 32'(AVM_WRITE), 32'd0);
    chk("rst_cs", 32'(AVM_CS), 32'd0);
    chk("rst_byte_en", 32'(AVM_BYTE_EN), 32'd0);
    chk("rst_addr", 32'(AVM_ADDR), 32'd0);
    chk("rst_data", AVM_WRITEDATA, 32'd0);
    chk("rst_busy", 32'(VOICE_BUSY), 32'd0);
    chk("rst_drop", 32'(DROP_COUNT), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("ready_after_release", 32'(EV_READY), 32'd1);

    // Directed sequence
    do_event(1'b1, 7'd60, 16'h4000, 16'h2000, 0);
    chk("busy_first_note", 32'(VOICE_BUSY), 32'h01);
    do_event(1'b1, 7'd60, 16'h1000, 16'h2000, 0);
    chk("busy_retrigger", 32'(VOICE_BUSY), 32'h01);
    do_event(1'b0, 7'd60, 16'h0, 16'h0, 0);
    chk("busy_after_off", 32'(VOICE_BUSY), 32'h00);
    for (int k = 0; k < 8; k++) do_event(1'b1, 7'(60 + k), 16'(k), 16'(k + 100), 0);
    chk("busy_all", 32'(VOICE_BUSY), 32'hFF);
    do_event(1'b1, 7'd68, 16'h1111, 16'h2222, 0);
    do_event(1'b1, 7'd69, 16'h3333, 16'h4444, 0);
    do_event(1'b0, 7'd99, 16'h0, 16'h0, 0);
    chk("drop_one", 32'(DROP_COUNT), 32'd1);
    do_event(1'b1, 7'd70, 16'h5555, 16'h6666, 2);

    // Randomized traffic over a narrow note range so retriggers and steals are common
    for (int k = 0; k < 80; k++)
      do_event($urandom_range(0, 2) != 0, 7'(60 + $urandom_range(0, 11)),
               16'($urandom), 16'($urandom), 1);

    // Reset in the middle of the AMP0 write
    guard = 0;
    while (EV_READY !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
    EV_VALID = 1'b1; EV_ON = 1'b1; EV_NOTE = 7'd80; EV_AMP1 = 16'h7; EV_AMP0 = 16'h8;
    @(posedge CLK);
    @(negedge CLK);
    EV_VALID = 1'b0;
    guard = 0;
    while (!(AVM_WRITE === 1'b1 && AVM_ADDR >= 6'd56) && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk("reached_amp0", 32'(guard < 20), 32'd1);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_write", 32'(AVM_WRITE), 32'd0);
    chk("midrst_busy", 32'(VOICE_BUSY), 32'd0);
    chk("midrst_drop", 32'(DROP_COUNT), 32'd0);
    chk("midrst_ready", 32'(EV_READY), 32'd0);
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    chk("midrst_ready_release", 32'(EV_READY), 32'd1);
    chk("midrst_no_write", 32'(AVM_WRITE), 32'd0);
    do_event(1'b1, 7'd61, 16'h0abc, 16'h0def, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_note_master.md
Name: avalon_note_master

Overview:
- Avalon-MM write master that turns note-on/note-off events into register writes to the synth control register file.
- Targets the KEY, FREQ, AMP1 and AMP0 banks: 64 x 32-bit word registers, 6-bit word address.
- Keeps an 8-voice allocation table, retriggers on repeated notes and steals voices round-robin when all are in use.
- Sits between the MIDI/sequencer event source and the control register slave. It shares that slave with the NIOS bus through the interconnect.

Parameters:
VOICES, 8, number of voice slots (1..8)
KEY_BASE, 32, word address of KEY0
FREQ_BASE, 40, word address of FREQ0
AMP1_BASE, 48, word address of AMP1_0
AMP0_BASE, 56, word address of AMP0_0

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-low (RESET=0 resets)
EV_VALID  in  1  event present
EV_READY  out  1  event accepted when EV_VALID&EV_READY at posedge
EV_ON  in  1  1=note-on, 0=note-off
EV_NOTE  in  7  note number
EV_AMP1  in  16  AMP1 value (note-on only)
EV_AMP0  in  16  AMP0 value (note-on only)
AVM_ADDR  out  6  word address
AVM_BYTE_EN  out  4  byte enables
AVM_WRITE  out  1  write strobe
AVM_CS  out  1  chip select
AVM_WRITEDATA  out  32  write data
AVM_WAITREQUEST  in  1  slave stall (tie 0 if unused)
VOICE_BUSY  out  VOICES  per-voice active flag
DROP_COUNT  out  16  unmatched note-offs, saturating

Behaviour:
- Reset (RESET=0 at posedge):
  - State goes to IDLE. Voice table, STEAL_PTR and DROP_COUNT are cleared.
  - All bus outputs are 0 and VOICE_BUSY is 0.
  - EV_READY is 0 while RESET=0 and 1 in the first cycle after release.
  - Reset mid-write abandons the write; AVM_WRITE is 0 from the next cycle. No cleanup writes are issued.
- All outputs are driven from registers or from registered state only.
- Voice table: per voice, an active bit and a 7-bit note.
- FSM states: IDLE, LOOKUP, WR_FREQ, WR_AMP1, WR_AMP0, WR_KEY.
- IDLE:
  - EV_READY=1.
  - On accept, capture EV_ON, EV_NOTE, EV_AMP1 and EV_AMP0, then go to LOOKUP.
- LOOKUP (one cycle, EV_READY=0), target voice v is chosen in priority order:
  - Note-on, note already active in voice i: v=i (retrigger).
  - Note-on, otherwise: v = lowest-index inactive voice.
  - Note-on, none free: v=STEAL_PTR, and STEAL_PTR increments mod VOICES.
  - Note-on then goes to WR_FREQ.
  - Note-off matching an active voice i: v=i, go to WR_KEY.
  - Note-off with no match: DROP_COUNT increments (saturates at 16'hFFFF), go to IDLE with no bus traffic.
- WR_* states:
  - AVM_WRITE=AVM_CS=1, AVM_BYTE_EN=4'hF.
  - Address and data are held stable while AVM_WAITREQUEST=1. The state advances at the posedge where AVM_WAITREQUEST=0.
- Write contents (address is 6-bit, base+v):
  - WR_FREQ: addr FREQ_BASE+v, data {25'b0,note}.
  - WR_AMP1: addr AMP1_BASE+v, data {16'b0,amp1}.
  - WR_AMP0: addr AMP0_BASE+v, data {16'b0,amp0}.
  - WR_KEY: addr KEY_BASE+v, data {31'b0,EV_ON}.
- Write order for note-on is FREQ, AMP1, AMP0, KEY. The gate is written last so pitch and levels are valid before the key rises.
- Voice table update (active bit and note) happens at WR_KEY completion: set on note-on, cleared on note-off. A stolen voice gets its new note.
- Latency with no waitrequest (accept edge ends cycle 0, LOOKUP in cycle 1):
  - Note-on: writes in cycles 2-5, EV_READY=1 in cycle 6.
  - Matched note-off: write in cycle 2, EV_READY=1 in cycle 3.
  - Unmatched note-off: EV_READY=1 in cycle 2.
- Outside WR_*: AVM_WRITE=AVM_CS=0, AVM_BYTE_EN=0, AVM_ADDR and AVM_WRITEDATA hold their last value.
- EV_VALID while busy is not consumed. The source must hold the event stable until accepted.
- AVM_READ is never issued.

Test Plan:
- Reset, then note-on 60, amp1 0x4000, amp0 0x2000 -> writes (40,60), (48,0x4000), (56,0x2000), (32,1) in cycles 2-5; VOICE_BUSY=8'h01; EV_READY in cycle 6.
- Note-on 60 again with amp1 0x1000 -> retrigger voice 0: writes 40, 48, 56, 32; VOICE_BUSY stays 8'h01.
- Note-off 60 -> single write (32,0) in cycle 2; VOICE_BUSY=8'h00; no other AVM_WRITE.
- Note-ons 60..67, then 68 -> VOICE_BUSY=8'hFF; note 68 steals voice 0 with writes (40,68)...(32,1); next steal (note 69) targets voice 1.
- Note-off 99 never played -> AVM_WRITE stays 0; DROP_COUNT=1; EV_READY in cycle 2.
- AVM_WAITREQUEST=1 for 3 cycles during WR_AMP1 -> addr 48 and data stable for 4 cycles, KEY write delayed 3 cycles. Then RESET=0 during WR_AMP0 -> AVM_WRITE=0 next cycle, VOICE_BUSY=0, DROP_COUNT=0, EV_READY=1 after release.
